f1_ddr_lane_adapter: RTL and testbench

//  Sits between the F1Shim AXI4 slave (memory) port and the shell DDR-C AXI4 interface.

---
 rtl/f1_ddr_lane_adapter.sv | 239 +++++++++++++++++++++++
 tb/tb_f1_ddr_lane_adapter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_ddr_lane_adapter.sv
// Narrow (64-bit) AXI4 master to wide (512-bit) DDR AXI4 lane adapter.
// Writes are steered into the address-selected lane; reads extract the lane tracked per outstanding burst.
module f1_ddr_lane_adapter #(
    parameter int unsigned NARROW_W = 64,
    parameter int unsigned WIDE_W   = 512,
    parameter int unsigned S_ADDR_W = 32,
    parameter int unsigned M_ADDR_W = 64,
    parameter int unsigned ID_W     = 16,
    parameter int unsigned RD_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    // narrow write address
    input  logic                  s_aw_valid,
    output logic                  s_aw_ready,
    input  logic [S_ADDR_W-1:0]   s_aw_bits_addr,
    input  logic [7:0]            s_aw_bits_len,
    input  logic [2:0]            s_aw_bits_size,
    input  logic [ID_W-1:0]       s_aw_bits_id,
    // narrow write data
    input  logic                  s_w_valid,
    output logic                  s_w_ready,
    input  logic [NARROW_W-1:0]   s_w_bits_data,
    input  logic [NARROW_W/8-1:0] s_w_bits_strb,
    input  logic                  s_w_bits_last,
    // narrow write response
    output logic                  s_b_valid,
    input  logic                  s_b_ready,
    output logic [1:0]            s_b_bits_resp,
    output logic [ID_W-1:0]       s_b_bits_id,
    // narrow read address
    input  logic                  s_ar_valid,
    output logic                  s_ar_ready,
    input  logic [S_ADDR_W-1:0]   s_ar_bits_addr,
    input  logic [7:0]            s_ar_bits_len,
    input  logic [2:0]            s_ar_bits_size,
    input  logic [ID_W-1:0]       s_ar_bits_id,
    // narrow read data
    output logic                  s_r_valid,
    input  logic                  s_r_ready,
    output logic [NARROW_W-1:0]   s_r_bits_data,
    output logic [1:0]            s_r_bits_resp,
    output logic                  s_r_bits_last,
    output logic [ID_W-1:0]       s_r_bits_id,
    // DDR write address
    output logic                  m_aw_valid,
    input  logic                  m_aw_ready,
    output logic [M_ADDR_W-1:0]   m_aw_bits_addr,
    output logic [7:0]            m_aw_bits_len,
    output logic [2:0]            m_aw_bits_size,
    output logic [1:0]            m_aw_bits_burst,
    output logic [ID_W-1:0]       m_aw_bits_id,
    // DDR write data
    output logic                  m_w_valid,
    input  logic                  m_w_ready,
    output logic [WIDE_W-1:0]     m_w_bits_data,
    output logic [WIDE_W/8-1:0]   m_w_bits_strb,
    output logic                  m_w_bits_last,
    output logic [ID_W-1:0]       m_w_bits_id,
    // DDR write response
    input  logic                  m_b_valid,
    output logic                  m_b_ready,
    input  logic [1:0]            m_b_bits_resp,
    input  logic [ID_W-1:0]       m_b_bits_id,
    // DDR read address
    output logic                  m_ar_valid,
    input  logic                  m_ar_ready,
    output logic [M_ADDR_W-1:0]   m_ar_bits_addr,
    output logic [7:0]            m_ar_bits_len,
    output logic [2:0]            m_ar_bits_size,
    output logic [1:0]            m_ar_bits_burst,
    output logic [ID_W-1:0]       m_ar_bits_id,
    // DDR read data
    input  logic                  m_r_valid,
    output logic                  m_r_ready,
    input  logic [WIDE_W-1:0]     m_r_bits_data,
    input  logic [1:0]            m_r_bits_resp,
    input  logic                  m_r_bits_last,
    input  logic [ID_W-1:0]       m_r_bits_id,
    output logic                  err
);

    localparam int unsigned LANES  = WIDE_W / NARROW_W;
    localparam int unsigned WSTRB  = WIDE_W / 8;
    localparam int unsigned OFF_W  = $clog2(NARROW_W / 8);
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned LO_W   = OFF_W + LANE_W;
    localparam int unsigned LOG_NW = $clog2(NARROW_W);
    localparam int unsigned PTR_W  = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(RD_DEPTH + 1);
    localparam logic [1:0]  INCR   = 2'b01;

    typedef enum logic {W_IDLE, W_DATA} wr_state_e;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [LO_W-1:0] off;
        logic [2:0]      size;
    } rd_ent_t;

    // ---------------- write path ----------------
    wr_state_e         wr_state_q, wr_state_d;
    logic [LO_W-1:0]   wr_addr_q, wr_addr_d;
    logic [2:0]        wr_size_q, wr_size_d;
    logic [ID_W-1:0]   wr_id_q, wr_id_d;
    logic              aw_hs;
    logic [LANE_W-1:0] wr_lane;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_size_d  = wr_size_q;
        wr_id_d    = wr_id_q;
        m_aw_valid = 1'b0;
        s_aw_ready = 1'b0;
        m_w_valid  = 1'b0;
        s_w_ready  = 1'b0;
        aw_hs      = 1'b0;
        if (!reset) begin
            unique case (wr_state_q)
                W_IDLE: begin
                    m_aw_valid = s_aw_valid;
                    s_aw_ready = m_aw_ready;
                    aw_hs      = s_aw_valid && m_aw_ready;
                    if (aw_hs) begin
                        wr_state_d = W_DATA;
                        wr_addr_d  = s_aw_bits_addr[LO_W-1:0];
                        wr_size_d  = s_aw_bits_size;
                        wr_id_d    = s_aw_bits_id;
                    end
                end
                W_DATA: begin
                    m_w_valid = s_w_valid;
                    s_w_ready = m_w_ready;
                    if (s_w_valid && m_w_ready) begin
                        wr_addr_d = wr_addr_q + ({{(LO_W-1){1'b0}}, 1'b1} << wr_size_q);
                        if (s_w_bits_last) wr_state_d = W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            wr_addr_q  <= '0;
            wr_size_q  <= '0;
            wr_id_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_size_q  <= wr_size_d;
            wr_id_q    <= wr_id_d;
        end
    end

    assign wr_lane         = wr_addr_q[LO_W-1:OFF_W];
    assign m_aw_bits_addr  = M_ADDR_W'(s_aw_bits_addr);
    assign m_aw_bits_len   = s_aw_bits_len;
    assign m_aw_bits_size  = s_aw_bits_size;
    assign m_aw_bits_burst = INCR;
    assign m_aw_bits_id    = s_aw_bits_id;
    assign m_w_bits_data   = {LANES{s_w_bits_data}};
    assign m_w_bits_strb   = WSTRB'(s_w_bits_strb) << {wr_lane, {OFF_W{1'b0}}};
    assign m_w_bits_last   = s_w_bits_last;
    assign m_w_bits_id     = wr_id_q;

    assign s_b_valid     = !reset && m_b_valid;
    assign m_b_ready     = !reset && s_b_ready;
    assign s_b_bits_resp = m_b_bits_resp;
    assign s_b_bits_id   = m_b_bits_id;

    // ---------------- read path ----------------
    rd_ent_t           fifo_q [RD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LO_W-1:0]   rd_off_q;
    logic              err_q;
    rd_ent_t           head;
    logic              empty, can_push, ar_hs, r_hs, r_last_hs;
    logic [LO_W-1:0]   rd_addr;
    logic [LANE_W-1:0] rd_lane;

    assign empty     = (cnt_q == '0);
    assign head      = fifo_q[rd_ptr_q];
    assign m_r_ready = !reset && s_r_ready && !empty;
    assign s_r_valid = !reset && m_r_valid && !empty;
    assign r_hs      = m_r_valid && m_r_ready;
    assign r_last_hs = r_hs && m_r_bits_last;
    // A last-beat pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign can_push   = (cnt_q < CNT_W'(RD_DEPTH)) || r_last_hs;
    assign m_ar_valid = !reset && s_ar_valid && can_push;
    assign s_ar_ready = !reset && m_ar_ready && can_push;
    assign ar_hs      = s_ar_valid && s_ar_ready;

    assign rd_addr       = head.off + rd_off_q;
    assign rd_lane       = rd_addr[LO_W-1:OFF_W];
    assign s_r_bits_data = m_r_bits_data[{rd_lane, {LOG_NW{1'b0}}} +: NARROW_W];
    assign s_r_bits_resp = m_r_bits_resp;
    assign s_r_bits_last = m_r_bits_last;
    assign s_r_bits_id   = m_r_bits_id;

    assign m_ar_bits_addr  = M_ADDR_W'(s_ar_bits_addr);
    assign m_ar_bits_len   = s_ar_bits_len;
    assign m_ar_bits_size  = s_ar_bits_size;
    assign m_ar_bits_burst = INCR;
    assign m_ar_bits_id    = s_ar_bits_id;

    always_ff @(posedge clock) begin
        if (ar_hs) fifo_q[wr_ptr_q] <= '{id: s_ar_bits_id, off: s_ar_bits_addr[LO_W-1:0], size: s_ar_bits_size};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rd_off_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (ar_hs) wr_ptr_q <= (wr_ptr_q == PTR_W'(RD_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            if (r_last_hs) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(RD_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
                rd_off_q <= '0;
            end else if (r_hs) begin
                rd_off_q <= rd_off_q + ({{(LO_W-1){1'b0}}, 1'b1} << head.size);
            end
            if (ar_hs && !r_last_hs) cnt_q <= cnt_q + CNT_W'(1);
            else if (!ar_hs && r_last_hs) cnt_q <= cnt_q - CNT_W'(1);
            if ((aw_hs && s_aw_bits_size > 3'd3) || (ar_hs && s_ar_bits_size > 3'd3) ||
                (m_r_valid && empty) || (r_hs && m_r_bits_id != head.id))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_f1_ddr_lane_adapter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_f1_ddr_lane_adapter;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_aw_valid, s_aw_ready;
    logic [31:0]  s_aw_bits_addr;
    logic [7:0]   s_aw_bits_len;
    logic [2:0]   s_aw_bits_size;
    logic [15:0]  s_aw_bits_id;
    logic         s_w_valid, s_w_ready;
    logic [63:0]  s_w_bits_data;
    logic [7:0]   s_w_bits_strb;
    logic         s_w_bits_last;
    logic         s_b_valid, s_b_ready;
    logic [1:0]   s_b_bits_resp;
    logic [15:0]  s_b_bits_id;
    logic         s_ar_valid, s_ar_ready;
    logic [31:0]  s_ar_bits_addr;
    logic [7:0]   s_ar_bits_len;
    logic [2:0]   s_ar_bits_size;
    logic [15:0]  s_ar_bits_id;
    logic         s_r_valid, s_r_ready;
    logic [63:0]  s_r_bits_data;
    logic [1:0]   s_r_bits_resp;
    logic         s_r_bits_last;
    logic [15:0]  s_r_bits_id;
    logic         m_aw_valid, m_aw_ready;
    logic [63:0]  m_aw_bits_addr;
    logic [7:0]   m_aw_bits_len;
    logic [2:0]   m_aw_bits_size;
    logic [1:0]   m_aw_bits_burst;
    logic [15:0]  m_aw_bits_id;
    logic         m_w_valid, m_w_ready;
    logic [511:0] m_w_bits_data;
    logic [63:0]  m_w_bits_strb;
    logic         m_w_bits_last;
    logic [15:0]  m_w_bits_id;
    logic         m_b_valid, m_b_ready;
    logic [1:0]   m_b_bits_resp;
    logic [15:0]  m_b_bits_id;
    logic         m_ar_valid, m_ar_ready;
    logic [63:0]  m_ar_bits_addr;
    logic [7:0]   m_ar_bits_len;
    logic [2:0]   m_ar_bits_size;
    logic [1:0]   m_ar_bits_burst;
    logic [15:0]  m_ar_bits_id;
    logic         m_r_valid, m_r_ready;
    logic [511:0] m_r_bits_data;
    logic [1:0]   m_r_bits_resp;
    logic         m_r_bits_last;
    logic [15:0]  m_r_bits_id;
    logic         err;

    f1_ddr_lane_adapter #(.NARROW_W(64), .WIDE_W(512), .S_ADDR_W(32), .M_ADDR_W(64),
                          .ID_W(16), .RD_DEPTH(8)) dut (
        .clock(clk), .reset(reset),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_bits_addr(s_aw_bits_addr),
        .s_aw_bits_len(s_aw_bits_len), .s_aw_bits_size(s_aw_bits_size), .s_aw_bits_id(s_aw_bits_id),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_bits_data(s_w_bits_data),
        .s_w_bits_strb(s_w_bits_strb), .s_w_bits_last(s_w_bits_last),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_bits_resp(s_b_bits_resp), .s_b_bits_id(s_b_bits_id),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_bits_addr(s_ar_bits_addr),
        .s_ar_bits_len(s_ar_bits_len), .s_ar_bits_size(s_ar_bits_size), .s_ar_bits_id(s_ar_bits_id),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_bits_data(s_r_bits_data),
        .s_r_bits_resp(s_r_bits_resp), .s_r_bits_last(s_r_bits_last), .s_r_bits_id(s_r_bits_id),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_bits_addr(m_aw_bits_addr),
        .m_aw_bits_len(m_aw_bits_len), .m_aw_bits_size(m_aw_bits_size), .m_aw_bits_burst(m_aw_bits_burst),
        .m_aw_bits_id(m_aw_bits_id),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_bits_data(m_w_bits_data),
        .m_w_bits_strb(m_w_bits_strb), .m_w_bits_last(m_w_bits_last), .m_w_bits_id(m_w_bits_id),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_bits_resp(m_b_bits_resp), .m_b_bits_id(m_b_bits_id),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_bits_addr(m_ar_bits_addr),
        .m_ar_bits_len(m_ar_bits_len), .m_ar_bits_size(m_ar_bits_size), .m_ar_bits_burst(m_ar_bits_burst),
        .m_ar_bits_id(m_ar_bits_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_bits_data(m_r_bits_data),
        .m_r_bits_resp(m_r_bits_resp), .m_r_bits_last(m_r_bits_last), .m_r_bits_id(m_r_bits_id),
        .err(err)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int unsigned id;
        int unsigned addr;
        int unsigned size;
        int unsigned beats;
    } rd_burst_t;

    rd_burst_t   rq[$];
    bit          model_ok = 0;
    bit          err_m = 0;
    bit          wbusy = 0;
    int unsigned waddr, wsize, wid, wbeats;

    function automatic int unsigned lane_of(int unsigned base, int unsigned beats, int unsigned size);
        return ((base + (beats << size)) >> 3) % 8;
    endfunction

    always @(negedge clk) begin : compare
        bit           empty, rhs, rlast, can, run;
        int unsigned  lw, rl;
        logic [511:0] ed;
        logic [63:0]  es;
        rd_burst_t    nb;
        run   = !reset;
        empty = (rq.size() == 0);
        rhs   = run && m_r_valid && s_r_ready && !empty;
        rlast = rhs && m_r_bits_last;
        can   = (rq.size() < 8) || rlast;
        if (model_ok) begin
            chk("err", err, err_m);
            chk("m_aw_valid", m_aw_valid, run && !wbusy && s_aw_valid);
            chk("s_aw_ready", s_aw_ready, run && !wbusy && m_aw_ready);
            chk("m_w_valid", m_w_valid, run && wbusy && s_w_valid);
            chk("s_w_ready", s_w_ready, run && wbusy && m_w_ready);
            chk("m_aw_addr", m_aw_bits_addr, {32'h0, s_aw_bits_addr});
            chk("m_aw_len", m_aw_bits_len, s_aw_bits_len);
            chk("m_aw_burst", m_aw_bits_burst, 2'b01);
            chk("m_ar_burst", m_ar_bits_burst, 2'b01);
            chk("m_ar_addr", m_ar_bits_addr, {32'h0, s_ar_bits_addr});
            chk("m_ar_id", m_ar_bits_id, s_ar_bits_id);
            if (run && wbusy) begin
                lw = lane_of(waddr, wbeats, wsize);
                es = 64'(s_w_bits_strb) << (8 * lw);
                for (int k = 0; k < 8; k++) ed[64*k +: 64] = s_w_bits_data;
                chk("m_w_strb", m_w_bits_strb, es);
                chk("m_w_data", m_w_bits_data, ed);
                chk("m_w_id", m_w_bits_id, 16'(wid));
                chk("m_w_last", m_w_bits_last, s_w_bits_last);
            end
            chk("s_b_valid", s_b_valid, run && m_b_valid);
            chk("m_b_ready", m_b_ready, run && s_b_ready);
            chk("s_b_resp_id", {s_b_bits_resp, s_b_bits_id}, {m_b_bits_resp, m_b_bits_id});
            chk("m_ar_valid", m_ar_valid, run && s_ar_valid && can);
            chk("s_ar_ready", s_ar_ready, run && m_ar_ready && can);
            chk("s_r_valid", s_r_valid, run && m_r_valid && !empty);
            chk("m_r_ready", m_r_ready, run && s_r_ready && !empty);
            if (run && !empty && m_r_valid) begin
                rl = lane_of(rq[0].addr, rq[0].beats, rq[0].size);
                chk("s_r_data", s_r_bits_data, m_r_bits_data[64*rl +: 64]);
                chk("s_r_last_id", {s_r_bits_last, s_r_bits_id}, {m_r_bits_last, m_r_bits_id});
            end
        end
        if (reset) begin
            model_ok = 1;
            wbusy = 0;
            err_m = 0;
            rq.delete();
        end else begin
            if (!wbusy && s_aw_valid && m_aw_ready) begin
                wbusy = 1; waddr = s_aw_bits_addr; wsize = s_aw_bits_size; wid = s_aw_bits_id; wbeats = 0;
                if (s_aw_bits_size > 3) err_m = 1;
            end else if (wbusy && s_w_valid && m_w_ready) begin
                wbeats++;
                if (s_w_bits_last) wbusy = 0;
            end
            if (m_r_valid && empty) err_m = 1;
            if (rhs) begin
                if (m_r_bits_id != 16'(rq[0].id)) err_m = 1;
                if (rlast) void'(rq.pop_front());
                else rq[0].beats++;
            end
            if (s_ar_valid && m_ar_ready && can) begin
                nb.id = s_ar_bits_id; nb.addr = s_ar_bits_addr; nb.size = s_ar_bits_size; nb.beats = 0;
                rq.push_back(nb);
                if (s_ar_bits_size > 3) err_m = 1;
            end
        end
    end

    // ---------------- DDR responder bookkeeping (random phase stimulus) ----------------
    typedef struct { int unsigned id; int unsigned len; } ddr_ent_t;
    ddr_ent_t    ddr_q[$];
    int unsigned rbeat = 0;

    always @(negedge clk) begin : ddr_track
        ddr_ent_t e;
        if (reset) begin
            ddr_q.delete();
            rbeat = 0;
        end else begin
            if (m_r_valid && m_r_ready && ddr_q.size() > 0) begin
                if (m_r_bits_last) begin void'(ddr_q.pop_front()); rbeat = 0; end
                else rbeat++;
            end
            if (m_ar_valid && m_ar_ready) begin
                e.id = m_ar_bits_id; e.len = m_ar_bits_len;
                ddr_q.push_back(e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clr();
        s_aw_valid = 0; s_aw_bits_addr = 0; s_aw_bits_len = 0; s_aw_bits_size = 0; s_aw_bits_id = 0;
        s_w_valid = 0; s_w_bits_data = 0; s_w_bits_strb = 0; s_w_bits_last = 0;
        s_b_ready = 0;
        s_ar_valid = 0; s_ar_bits_addr = 0; s_ar_bits_len = 0; s_ar_bits_size = 0; s_ar_bits_id = 0;
        s_r_ready = 0;
        m_aw_ready = 0; m_w_ready = 0; m_b_valid = 0; m_b_bits_resp = 0; m_b_bits_id = 0;
        m_ar_ready = 0; m_r_valid = 0; m_r_bits_data = 0; m_r_bits_resp = 0; m_r_bits_last = 0; m_r_bits_id = 0;
    endtask

    task automatic rand512(output logic [511:0] d);
        for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
    endtask

    int unsigned  wlanes [4] = '{6, 7, 0, 1};
    logic [63:0]  rexp   [3] = '{64'hC0DE_0000_0000_0007, 64'hC0DE_0000_0000_0007, 64'hC0DE_0000_0000_0000};
    logic [511:0] tmp;

    initial begin
        clr();
        reset = 1;
        s_aw_valid = 1; s_w_valid = 1; s_ar_valid = 1; m_aw_ready = 1; m_w_ready = 1;
        m_ar_ready = 1; s_r_ready = 1; m_b_valid = 1; s_b_ready = 1;
        repeat (2) tick();
        sample();
        chk("rst_valids", {m_aw_valid, m_w_valid, m_ar_valid, s_b_valid, s_r_valid}, 5'b0);
        chk("rst_readys", {s_aw_ready, s_w_ready, s_ar_ready, m_b_ready, m_r_ready}, 5'b0);
        chk("rst_err", err, 1'b0);
        tick();
        clr();
        reset = 0;

        // single-beat write to lane 1
        tick();
        s_aw_valid = 1; s_aw_bits_addr = 32'h48; s_aw_bits_size = 3; s_aw_bits_id = 16'h7; m_aw_ready = 1;
        sample();
        chk("d1_aw_valid", m_aw_valid, 1'b1);
        chk("d1_aw_addr", m_aw_bits_addr, 64'h48);
        tick();
        s_aw_valid = 0; s_w_valid = 1; s_w_bits_data = 64'hDEAD_BEEF_0123_4567; s_w_bits_strb = 8'hFF;
        s_w_bits_last = 1; m_w_ready = 1;
        sample();
        chk("d1_w_strb", m_w_bits_strb, 64'hFF00);
        tmp = m_w_bits_data;
        chk("d1_w_data_lane1", tmp[127:64], 64'hDEAD_BEEF_0123_4567);
        chk("d1_w_id", m_w_bits_id, 16'h7);
        tick();
        s_w_valid = 0;
        sample();
        chk("d1_idle_aw_ready", s_aw_ready, 1'b1);

        // write burst crossing the wide-word boundary
        tick();
        s_aw_valid = 1; s_aw_bits_addr = 32'h30; s_aw_bits_len = 3; s_aw_bits_size = 3; s_aw_bits_id = 16'h2;
        sample();
        tick();
        s_aw_valid = 0;
        for (int i = 0; i < 4; i++) begin
            s_w_valid = 1; s_w_bits_strb = 8'hFF; s_w_bits_last = (i == 3); s_w_bits_data = {$urandom, $urandom};
            sample();
            chk("d2_w_strb", m_w_bits_strb, 64'hFF << (8 * wlanes[i]));
            chk("d2_w_last", m_w_bits_last, (i == 3));
            tick();
        end
        s_w_valid = 0;
        sample();
        chk("d2_idle_w_ready", s_w_ready, 1'b0);
        chk("d2_idle_aw_ready", s_aw_ready, 1'b1);

        // read burst with size 2 wrapping from lane 7 to lane 0
        tick();
        m_aw_ready = 0; m_w_ready = 0;
        s_ar_valid = 1; s_ar_bits_addr = 32'h38; s_ar_bits_len = 2; s_ar_bits_size = 2; s_ar_bits_id = 16'h3;
        m_ar_ready = 1;
        sample();
        chk("d3_ar_ready", s_ar_ready, 1'b1);
        tick();
        s_ar_valid = 0; m_r_valid = 1; m_r_bits_id = 16'h3; s_r_ready = 1;
        for (int k = 0; k < 8; k++) m_r_bits_data[64*k +: 64] = 64'hC0DE_0000_0000_0000 + 64'(k);
        for (int i = 0; i < 3; i++) begin
            m_r_bits_last = (i == 2);
            sample();
            chk("d3_r_data", s_r_bits_data, rexp[i]);
            chk("d3_r_last", s_r_bits_last, (i == 2));
            tick();
        end
        m_r_valid = 0; m_r_bits_last = 0;

        // fill the read tracker, ninth AR waits for the first rlast
        s_ar_valid = 1; s_ar_bits_addr = 0; s_ar_bits_len = 0; s_ar_bits_size = 3;
        for (int i = 0; i < 8; i++) begin
            s_ar_bits_id = 16'(i);
            sample();
            chk("d4_ar_accept", s_ar_ready, 1'b1);
            tick();
        end
        s_ar_bits_id = 16'h8;
        sample();
        chk("d4_ar9_blocked", m_ar_valid, 1'b0);
        tick();
        m_r_valid = 1; m_r_bits_id = 16'h0; m_r_bits_last = 1;
        sample();
        chk("d4_ar9_released", {m_ar_valid, s_ar_ready}, 2'b11);
        tick();
        s_ar_valid = 0;
        for (int i = 1; i <= 8; i++) begin
            m_r_bits_id = 16'(i);
            sample();
            chk("d4_drain", s_r_valid, 1'b1);
            tick();
        end
        m_r_valid = 0;
        sample();
        chk("d4_empty_hold", m_r_ready, 1'b0);
        chk("d4_err", err, 1'b0);

        // ID mismatch makes err sticky while data still flows
        tick();
        s_ar_valid = 1; s_ar_bits_len = 1; s_ar_bits_id = 16'h3;
        tick();
        s_ar_valid = 0; m_r_valid = 1; m_r_bits_id = 16'h5; m_r_bits_last = 0;
        sample();
        chk("d5_mismatch_delivered", s_r_valid, 1'b1);
        tick();
        m_r_bits_id = 16'h3; m_r_bits_last = 1;
        sample();
        chk("d5_err_set", err, 1'b1);
        tick();
        m_r_valid = 0; s_ar_valid = 1; s_ar_bits_len = 0; s_ar_bits_id = 16'h4;
        tick();
        s_ar_valid = 0; m_r_valid = 1; m_r_bits_id = 16'h4; m_r_bits_last = 1;
        sample();
        chk("d5_next_burst", s_r_valid, 1'b1);
        tick();
        m_r_valid = 0;
        sample();
        chk("d5_err_sticky", err, 1'b1);

        // reset during beat 2 of a 4-beat write
        tick();
        clr();
        m_aw_ready = 1; m_w_ready = 1;
        s_aw_valid = 1; s_aw_bits_len = 3; s_aw_bits_size = 3;
        tick();
        s_aw_valid = 0; s_w_valid = 1; s_w_bits_strb = 8'hFF;
        tick();
        reset = 1;
        tick();
        reset = 0;
        sample();
        chk("d6_w_ready", s_w_ready, 1'b0);
        chk("d6_w_valid", m_w_valid, 1'b0);
        chk("d6_err", err, 1'b0);
        chk("d6_idle", s_aw_ready, 1'b1);

        // oversize AW still forwarded, flags err
        tick();
        s_w_valid = 0; s_aw_valid = 1; s_aw_bits_size = 3'd4; s_aw_bits_len = 0;
        sample();
        chk("d7_big_fwd", m_aw_valid, 1'b1);
        tick();
        s_aw_valid = 0;
        sample();
        chk("d7_big_err", err, 1'b1);
        tick();
        reset = 1;
        repeat (2) tick();
        clr();
        reset = 0;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            tick();
            s_aw_valid = $urandom_range(0, 1); s_aw_bits_addr = $urandom; s_aw_bits_len = 8'($urandom_range(0, 3));
            s_aw_bits_size = 3'($urandom_range(0, 3)); s_aw_bits_id = 16'($urandom);
            s_w_valid = $urandom_range(0, 1); s_w_bits_data = {$urandom, $urandom}; s_w_bits_strb = 8'($urandom);
            s_w_bits_last = ($urandom_range(0, 3) == 0);
            s_ar_valid = $urandom_range(0, 1); s_ar_bits_addr = $urandom; s_ar_bits_len = 8'($urandom_range(0, 3));
            s_ar_bits_size = 3'($urandom_range(0, 3)); s_ar_bits_id = 16'($urandom);
            s_r_ready = $urandom_range(0, 1); s_b_ready = $urandom_range(0, 1);
            m_aw_ready = $urandom_range(0, 1); m_w_ready = $urandom_range(0, 1); m_ar_ready = $urandom_range(0, 1);
            m_b_valid = $urandom_range(0, 1); m_b_bits_resp = 2'($urandom); m_b_bits_id = 16'($urandom);
            rand512(tmp);
            m_r_bits_data = tmp; m_r_bits_resp = 2'($urandom);
            if (ddr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                m_r_valid = 1; m_r_bits_id = 16'(ddr_q[0].id); m_r_bits_last = (rbeat == ddr_q[0].len);
            end else begin
                m_r_valid = 0; m_r_bits_id = 16'($urandom); m_r_bits_last = $urandom_range(0, 1);
            end
        end
        tick();
        clr();
        sample();
        chk("rand_err_clean", err, 1'b0);
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
